// File: rtl/mem_access_stage_if.sv
// Signal bundle of mem_access_stage: upstream instruction handshake, data-memory bus and result port.
// The "master" modport is the stage's view; "slave" is the view of its surroundings.
interface mem_access_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Handshakes: an instruction transfers on a clk edge where in_valid and in_ready are both 1;
  // a memory request transfers on an edge where dmem_req and dmem_gnt are both 1, and read data
  // transfers on an edge where dmem_rvalid is 1 while the stage is waiting for it.
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic [3:0]          in_rd;
  logic [1:0]          in_mem_op;
  logic                in_byte;
  logic                in_tag;

  logic                dmem_req;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]   dmem_wdata;
  logic [DATA_W/8-1:0] dmem_be;
  logic                dmem_gnt;
  logic                dmem_rvalid;
  logic [DATA_W-1:0]   dmem_rdata;

  logic                out_valid;
  logic [31:0]         out_instr;
  logic [DATA_W-1:0]   out_data;
  logic [3:0]          out_rd;
  logic                out_w_en;

  logic [1:0]          dbg_state;

  modport master (
    input  in_valid, in_instr, in_addr, in_wdata, in_rd, in_mem_op, in_byte, in_tag,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output in_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output out_valid, out_instr, out_data, out_rd, out_w_en,
    output dbg_state
  );

  modport slave (
    output in_valid, in_instr, in_addr, in_wdata, in_rd, in_mem_op, in_byte, in_tag,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  in_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  out_valid, out_instr, out_data, out_rd, out_w_en,
    input  dbg_state
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one instruction in flight, loads/stores over a req/gnt/rvalid bus,
// pass-through of ALU results, branch-tag squashing and a request timeout.
module mem_access_stage #(
  parameter int DATA_W  = 32,  // multiple of 8, at least 16
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16   // 0 disables the timeout
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  output logic               branch_ref_global,
  output logic               timeout_err,
  mem_access_stage_if.master bus
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              ref_q;
  logic              ready_q;
  logic              pt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        rd_q;
  logic [1:0]        op_q;
  logic              byte_q;
  logic              tag_q;

  logic              accept;
  logic              in_is_mem;
  logic              in_live;
  logic              busy;
  logic [CNT_W-1:0]  cnt_inc;
  logic              to_hit;
  logic              load_capture;
  logic              res_valid;
  logic              res_load;
  logic [LANE_W-1:0] lane;
  logic [NB-1:0]     lane_be;
  logic [7:0]        load_byte;
  logic [DATA_W-1:0] pt_data;

  // The reference flips combinationally with the branch pulse so an instruction accepted in the
  // same cycle as the branch is already judged against the new reference.
  assign branch_ref_global = rst_n & (ref_q ^ branch_taken);

  assign accept    = bus.in_valid & bus.in_ready;
  assign in_is_mem = (bus.in_mem_op == OP_LOAD) || (bus.in_mem_op == OP_STORE);
  assign in_live   = (bus.in_tag == branch_ref_global);
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);

  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign to_hit       = TO_EN && busy && (cnt_inc == CNT_W'(TIMEOUT));
  assign load_capture = ((state_q == ST_REQ) && bus.dmem_gnt && (op_q == OP_LOAD) && bus.dmem_rvalid)
                     || ((state_q == ST_WAIT) && bus.dmem_rvalid);

  // Finishing the transaction (moving to OUT) wins over a timeout in the same cycle; a grant
  // without data in the last allowed cycle does not, since the load could not finish in time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_is_mem && in_live) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.dmem_gnt && ((op_q == OP_STORE) || bus.dmem_rvalid)) state_d = ST_OUT;
        else if (to_hit)                                              state_d = ST_IDLE;
        else if (bus.dmem_gnt)                                        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.dmem_rvalid) state_d = ST_OUT;
        else if (to_hit)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ref_q   <= 1'b0;
      ready_q <= 1'b0;
      pt_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      byte_q  <= 1'b0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= branch_ref_global;
      ready_q <= 1'b1;
      pt_q    <= accept && !in_is_mem && in_live;
      cnt_q   <= busy ? cnt_inc : '0;
      if (to_hit && (state_d == ST_IDLE)) err_q <= 1'b1;
      if (accept) begin
        instr_q <= bus.in_instr;
        addr_q  <= bus.in_addr;
        wdata_q <= bus.in_wdata;
        rd_q    <= bus.in_rd;
        op_q    <= bus.in_mem_op;
        byte_q  <= bus.in_byte;
        tag_q   <= bus.in_tag;
      end
      if (load_capture) rdata_q <= bus.dmem_rdata;
    end
  end

  assign lane      = addr_q[LANE_W-1:0];
  assign lane_be   = NB'(1) << lane;
  assign load_byte = rdata_q[{lane, 3'b000} +: 8];

  if (ADDR_W >= DATA_W) begin : g_pt_trunc
    assign pt_data = addr_q[DATA_W-1:0];
  end else begin : g_pt_zext
    assign pt_data = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
  end

  assign bus.in_ready  = ready_q && (state_q == ST_IDLE);
  assign bus.dbg_state = state_q;

  // Memory bus fields are only meaningful while requesting; they stay constant through REQ
  // because they derive purely from captured registers.
  assign bus.dmem_req   = (state_q == ST_REQ);
  assign bus.dmem_we    = bus.dmem_req && (op_q == OP_STORE);
  assign bus.dmem_addr  = !bus.dmem_req ? '0 :
                          byte_q ? addr_q : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dmem_be    = !bus.dmem_req ? '0 : (byte_q ? lane_be : '1);
  assign bus.dmem_wdata = !bus.dmem_req ? '0 :
                          byte_q ? {NB{wdata_q[7:0]}} : wdata_q;

  // A branch seen between accept and OUT has moved ref_q away from the captured tag.
  assign res_valid = (state_q == ST_OUT) && (tag_q == ref_q);
  assign res_load  = res_valid && (op_q == OP_LOAD);

  assign bus.out_valid = pt_q | res_valid;
  assign bus.out_w_en  = pt_q | res_load;
  assign bus.out_data  = pt_q     ? pt_data :
                         res_load ? (byte_q ? {{(DATA_W-8){1'b0}}, load_byte} : rdata_q) :
                         '0;
  assign bus.out_instr = bus.out_valid ? instr_q : '0;
  assign bus.out_rd    = bus.out_valid ? rd_q : '0;

  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random transactions scored against a
// transaction-level model of branch reference, squashing, timeout and result formatting.
module tb_mem_access_stage;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int EXP_W   = 32 + 4 + 1 + DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_taken = 1'b0;
  logic branch_ref_global;
  logic timeout_err;

  mem_access_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .branch_taken     (branch_taken),
    .branch_ref_global(branch_ref_global),
    .timeout_err      (timeout_err),
    .bus              (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: branch parity and sticky error
  bit ref_m = 1'b0;
  bit err_m = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every result pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && (bus.out_valid === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", bus.out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_ctl", {bus.out_instr, bus.out_rd, bus.out_w_en}, mon_e[EXP_W-1:DATA_W]);
        if (mon_e[DATA_W]) check("out_data", bus.out_data, mon_e[DATA_W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_addr     = '0;
    bus.in_wdata    = '0;
    bus.in_rd       = '0;
    bus.in_mem_op   = '0;
    bus.in_byte     = 1'b0;
    bus.in_tag      = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = '0;
    branch_taken    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_dmem_req", bus.dmem_req, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_bref", branch_ref_global, 1'b0);
    ref_m = 1'b0;
    err_m = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_clk", bus.in_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rel_ready_after_clk", bus.in_ready, 1'b1);
  endtask

  // One instruction end to end. g: grant in busy cycle g+1; r: extra cycles to read data;
  // br_k: busy cycle carrying a branch pulse (0 = none).
  task automatic run_txn(input logic [1:0] op, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic tag, input logic br_acc,
                         input int g, input int r, input int br_k, input logic [31:0] rdata);
    logic [31:0] instr;
    logic [3:0]  rd;
    logic [31:0] e_addr, e_wdata, ld_val;
    logic [3:0]  e_be;
    bit is_load, is_store, squash, completes;
    int n_req, last, ld_extra;
    instr    = $urandom;
    rd       = 4'($urandom_range(0, 15));
    is_load  = (op == 2'b01);
    is_store = (op == 2'b10);
    next_cycle();
    idle_inputs();
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_rd     = rd;
    bus.in_mem_op = op;
    bus.in_byte   = byt;
    bus.in_tag    = tag;
    branch_taken  = br_acc;
    @(negedge clk);
    check("acc_ready", bus.in_ready, 1'b1);
    check("bref_acc", branch_ref_global, ref_m ^ br_acc);
    squash = (tag != (ref_m ^ br_acc));
    ref_m  = ref_m ^ br_acc;
    next_cycle();
    idle_inputs();
    if (!is_load && !is_store) begin
      if (!squash) exp_q.push_back({instr, rd, 1'b1, addr});
      @(negedge clk);
      check("pt_no_req", bus.dmem_req, 1'b0);
      check("pt_err", timeout_err, err_m);
      return;
    end
    if (squash) begin
      @(negedge clk);
      check("sq_no_req", bus.dmem_req, 1'b0);
      check("sq_ready", bus.in_ready, 1'b1);
      return;
    end
    e_addr    = byt ? addr : {addr[31:2], 2'b00};
    e_be      = byt ? (4'b0001 << addr[1:0]) : 4'hF;
    e_wdata   = byt ? {4{wdata[7:0]}} : wdata;
    ld_val    = byt ? ((rdata >> (8 * addr[1:0])) & 32'hFF) : rdata;
    ld_extra  = is_load ? r : 0;
    completes = (g + 1 + ld_extra) <= TIMEOUT;
    last      = completes ? (g + 1 + ld_extra) : TIMEOUT;
    n_req     = (g + 1 < TIMEOUT) ? (g + 1) : TIMEOUT;
    for (int k = 1; k <= last; k++) begin
      branch_taken    = (k == br_k);
      bus.dmem_gnt    = (k == g + 1);
      bus.dmem_rvalid = is_load && ((k == g + 1 + r) || (k < g + 1 && $urandom_range(0, 1) == 1));
      bus.dmem_rdata  = (k == g + 1 + r) ? rdata : $urandom;
      @(negedge clk);
      check("req", bus.dmem_req, k <= n_req);
      if (k <= n_req) begin
        check("addr", bus.dmem_addr, e_addr);
        check("be", bus.dmem_be, e_be);
        check("we", bus.dmem_we, is_store);
        if (is_store) check("wdata", bus.dmem_wdata, e_wdata);
      end
      if (k == br_k) ref_m = ~ref_m;
      next_cycle();
    end
    idle_inputs();
    bus.dmem_rvalid = ($urandom_range(0, 1) == 1);
    bus.dmem_rdata  = $urandom;
    if (completes && (tag == ref_m)) exp_q.push_back({instr, rd, is_load, (is_load ? ld_val : 32'h0)});
    if (!completes) err_m = 1'b1;
    @(negedge clk);
    check("tail_req", bus.dmem_req, 1'b0);
    check("tail_ready", bus.in_ready, !completes);
    check("tail_err", timeout_err, err_m);
  endtask

  task automatic reset_in_wait();
    next_cycle();
    idle_inputs();
    bus.in_valid  = 1'b1;
    bus.in_instr  = $urandom;
    bus.in_addr   = $urandom;
    bus.in_mem_op = 2'b01;
    bus.in_tag    = ref_m;
    next_cycle();
    idle_inputs();
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    check("rw_req", bus.dmem_req, 1'b1);
    next_cycle();
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    check("rw_wait_req", bus.dmem_req, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rw_rst_req", bus.dmem_req, 1'b0);
    check("rw_rst_ready", bus.in_ready, 1'b0);
    check("rw_rst_out", bus.out_valid, 1'b0);
    check("rw_rst_err", timeout_err, 1'b0);
    ref_m = 1'b0;
    err_m = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = $urandom;
    @(negedge clk);
    check("rw_late_rv_out", bus.out_valid, 1'b0);
    check("rw_ready", bus.in_ready, 1'b1);
    next_cycle();
    bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    check("rw_late_rv_out2", bus.out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [1:0]  r_op;
  logic        r_byte, r_tag, r_bacc;
  logic [31:0] r_addr, r_wdata, r_rdata;

  initial begin
    apply_reset();
    run_txn(2'b00, 1'b0, 32'h1234, $urandom, 1'b0, 1'b0, 0, 0, 0, 32'h0);
    run_txn(2'b10, 1'b1, 32'h103, 32'hAB, 1'b0, 1'b0, 2, 0, 0, 32'h0);
    run_txn(2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h11223344);
    run_txn(2'b01, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 0, 2, 2, 32'hCAFEF00D);
    run_txn(2'b00, 1'b0, 32'h55, 32'h0, 1'b0, 1'b0, 0, 0, 0, 32'h0);
    run_txn(2'b00, 1'b0, 32'h66, 32'h0, 1'b1, 1'b0, 0, 0, 0, 32'h0);
    run_txn(2'b10, 1'b0, 32'h300, 32'h12345678, ref_m, 1'b0, 10, 0, 0, 32'h0);
    run_txn(2'b11, 1'b0, 32'h77, 32'h0, ref_m, 1'b0, 0, 0, 0, 32'h0);
    run_txn(2'b01, 1'b0, 32'h400, 32'h0, ref_m, 1'b0, 1, 5, 0, 32'hDEADBEEF);
    reset_in_wait();
    for (int i = 0; i < 200; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_byte  = ($urandom_range(0, 1) == 1);
      r_tag   = ref_m ^ ($urandom_range(0, 4) == 0);
      r_bacc  = ($urandom_range(0, 5) == 0);
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      run_txn(r_op, r_byte, r_addr, r_wdata, r_tag, r_bacc,
              $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 6), r_rdata);
    end
    repeat (3) next_cycle();
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
